// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin arbiter that shares one serial transmitter between N_REQ byte
// producers. The winner's byte and parity mode are latched, and the transmitter
// gets a one-cycle active-low start pulse. The arbiter then waits for a rising
// edge of the transmitter's done interrupt and acks the owning requester.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_req              per-requester level request
//   i_req_data         byte k at [8k+7:8k]
//   i_req_parity       parity mode k at [2k+1:2k] (00 even, 01 odd, 10 none)
//   o_grant            one-hot owner, LOAD..ACK
//   o_ack              one-cycle completion pulse to the owner
//   o_err              one-cycle pulse with o_ack on frame timeout
//   o_busy             high outside IDLE
//   o_tx_start_n       active-low one-cycle transmitter start
//   o_tx_data          byte to the transmitter
//   o_tx_parity        parity mode to the transmitter
//   i_tx_int           transmitter done interrupt (level)
//
// Build option: define UART_TX_ARB_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYC cycles in WAIT. When this is left undefined, WAIT holds
// indefinitely and o_err is 0.

module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [2*N_REQ-1:0] i_req_parity,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_tx_start_n,
    output logic [7:0]         o_tx_data,
    output logic [1:0]         o_tx_parity,
    input  logic               i_tx_int
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StAck  = 2'd3;

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("uart_tx_arbiter: N_REQ must be 2..16 and TIMEOUT_CYC >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       par_q, par_d;
    logic             start_n_q, start_n_d;
    logic             tx_int_q;
    logic             done;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;

    // Only a fresh rising edge ends a frame; a level left high by the
    // previous frame must not complete the next one.
    assign done = i_tx_int & ~tx_int_q;

    // Search upward from the slot after the last owner, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!win_found && i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    logic             err_q, err_d;

    // cnt_q counts completed WAIT cycles, so this fires in the
    // TIMEOUT_CYC-th WAIT cycle.
    assign timeout = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StLoad) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Done takes precedence over a coincident timeout.
    assign err_d = timeout & ~done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        data_d    = data_q;
        par_d     = par_q;
        start_n_d = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d   = StLoad;
                    owner_d   = win_idx;
                    grant_d   = N_REQ'(1) << win_idx;
                    data_d    = i_req_data[8*win_idx +: 8];
                    par_d     = i_req_parity[2*win_idx +: 2];
                    start_n_d = 1'b0;
                end
            end
            StLoad: begin
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    state_d = StAck;
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = StAck;
`endif
                end
            end
            StAck: begin
                ptr_d   = owner_q;
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            ptr_q     <= IDX_W'(N_REQ - 1);
            owner_q   <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            par_q     <= 2'b10;
            start_n_q <= 1'b1;
            tx_int_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            par_q     <= par_d;
            start_n_q <= start_n_d;
            tx_int_q  <= i_tx_int;
        end
    end

    assign o_grant      = grant_q;
    assign o_ack        = (state_q == StAck) ? grant_q : '0;
    assign o_busy       = (state_q != StIdle);
    assign o_tx_start_n = start_n_q;
    assign o_tx_data    = data_q;
    assign o_tx_parity  = par_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_par;
    logic        tx_int;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        err;
    logic        busy;
    logic        start_n;
    logic [7:0]  tx_data;
    logic [1:0]  tx_par;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .TIMEOUT_CYC (50)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_req_data   (req_data),
        .i_req_parity (req_par),
        .o_grant      (grant),
        .o_ack        (ack),
        .o_err        (err),
        .o_busy       (busy),
        .o_tx_start_n (start_n),
        .o_tx_data    (tx_data),
        .o_tx_parity  (tx_par),
        .i_tx_int     (tx_int)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       tx_int;
        logic [3:0] grant;
        logic [3:0] ack;
        logic       busy;
        logic       start_n;
        logic [7:0] data;
        logic [1:0] par;
    } vec_t;

    vec_t tbl[20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (start_n !== 1'b0 && n < 20);
        check({name, "_seen"}, {31'd0, start_n}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ack_cnt;
        int n;

        // Constant table data: d0=A5 p0=00, d1=11 p1=10, d2=22 p2=11, d3=5A p3=01.
        //           rst   req   txi   grant ack   busy  st_n  data   par
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'h00, 2'b10};
        tbl[1]  = '{1'b0, 4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 8'hA5, 2'b00};
        tbl[2]  = '{1'b0, 4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 8'hA5, 2'b00};
        tbl[3]  = '{1'b0, 4'h1, 1'b0, 4'h1, 4'h0, 1'b1, 1'b1, 8'hA5, 2'b00};
        tbl[4]  = '{1'b0, 4'h1, 1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 8'hA5, 2'b00};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 8'hA5, 2'b00};
        tbl[6]  = '{1'b0, 4'h8, 1'b0, 4'h8, 4'h0, 1'b1, 1'b0, 8'h5A, 2'b01};
        tbl[7]  = '{1'b0, 4'h8, 1'b0, 4'h8, 4'h0, 1'b1, 1'b1, 8'h5A, 2'b01};
        tbl[8]  = '{1'b0, 4'h8, 1'b1, 4'h8, 4'h8, 1'b1, 1'b1, 8'h5A, 2'b01};
        tbl[9]  = '{1'b0, 4'h6, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 8'h5A, 2'b01};
        tbl[10] = '{1'b0, 4'h6, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0, 8'h11, 2'b10};
        tbl[11] = '{1'b0, 4'h6, 1'b1, 4'h2, 4'h0, 1'b1, 1'b1, 8'h11, 2'b10};
        tbl[12] = '{1'b0, 4'h6, 1'b1, 4'h2, 4'h0, 1'b1, 1'b1, 8'h11, 2'b10};
        tbl[13] = '{1'b0, 4'h6, 1'b0, 4'h2, 4'h0, 1'b1, 1'b1, 8'h11, 2'b10};
        tbl[14] = '{1'b0, 4'h6, 1'b1, 4'h2, 4'h2, 1'b1, 1'b1, 8'h11, 2'b10};
        tbl[15] = '{1'b0, 4'h6, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 8'h11, 2'b10};
        tbl[16] = '{1'b0, 4'h6, 1'b1, 4'h4, 4'h0, 1'b1, 1'b0, 8'h22, 2'b11};
        tbl[17] = '{1'b0, 4'h6, 1'b0, 4'h4, 4'h0, 1'b1, 1'b1, 8'h22, 2'b11};
        tbl[18] = '{1'b0, 4'h6, 1'b1, 4'h4, 4'h4, 1'b1, 1'b1, 8'h22, 2'b11};
        tbl[19] = '{1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'h22, 2'b11};

        rst      = 1'b1;
        req      = 4'h0;
        tx_int   = 1'b0;
        req_data = 32'h5A2211A5;
        req_par  = 8'h78;

        // Packed as {err, grant, ack, busy, start_n, data, parity}.
        for (int i = 0; i < 20; i++) begin
            rst    = tbl[i].rst;
            req    = tbl[i].req;
            tx_int = tbl[i].tx_int;
            step();
            check($sformatf("vec%0d", i),
                  {11'd0, err, grant, ack, busy, start_n, tx_data, tx_par},
                  {11'd0, 1'b0, tbl[i].grant, tbl[i].ack, tbl[i].busy, tbl[i].start_n,
                   tbl[i].data, tbl[i].par});
        end

        // Round robin with all four requesting, fixed 2-cycle WAIT.
        rst = 1'b1; req = 4'h0; tx_int = 1'b0;
        step();
        req_data = 32'h13121110;
        req_par  = 8'h00;
        rst      = 1'b0;
        req      = 4'hF;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            wait_start("rr_start", n);
            check(k == 0 ? "rr_latency" : "rr_gap", n, (k == 0) ? 32'd1 : 32'd2);
            check("rr_grant", {28'd0, grant}, {28'd0, exp_g});
            check("rr_data", {24'd0, tx_data}, 32'h10 + 32'(k % 4));
            step();
            step();
            tx_int = 1'b1;
            step();
            check("rr_ack", {28'd0, ack}, {28'd0, exp_g});
            tx_int = 1'b0;
        end

        // Interrupt already high when the frame starts: only the next rising edge counts.
        rst = 1'b1; req = 4'h0; tx_int = 1'b0;
        step();
        rst      = 1'b0;
        req_data = 32'h00000077;
        req_par  = 8'h00;
        req      = 4'b0001;
        tx_int   = 1'b1;
        ack_cnt  = 0;
        step();
        check("hi_load", {31'd0, start_n}, 32'd0);
        step();
        ack_cnt += (ack != 4'h0) ? 1 : 0;
        step();
        ack_cnt += (ack != 4'h0) ? 1 : 0;
        check("hi_no_early_ack", {28'd0, ack}, 32'd0);
        tx_int = 1'b0;
        step();
        ack_cnt += (ack != 4'h0) ? 1 : 0;
        tx_int = 1'b1;
        step();
        ack_cnt += (ack != 4'h0) ? 1 : 0;
        check("hi_ack", {28'd0, ack}, 32'h1);
        req = 4'h0;
        step();
        ack_cnt += (ack != 4'h0) ? 1 : 0;
        step();
        ack_cnt += (ack != 4'h0) ? 1 : 0;
        check("hi_ack_count", ack_cnt, 32'd1);

        // Data change and request drop during WAIT do not affect the frame.
        req_data = 32'h003C0000;
        req      = 4'b0100;
        tx_int   = 1'b0;
        step();
        check("chg_grant", {28'd0, grant}, 32'h4);
        check("chg_load_data", {24'd0, tx_data}, 32'h3C);
        step();
        req_data = 32'h00FF0000;
        req      = 4'h0;
        step();
        step();
        check("chg_data_held", {24'd0, tx_data}, 32'h3C);
        check("chg_busy", {31'd0, busy}, 32'd1);
        tx_int = 1'b1;
        step();
        check("chg_ack", {28'd0, ack}, 32'h4);
        check("chg_ack_data", {24'd0, tx_data}, 32'h3C);
        tx_int = 1'b0;
        step();

        // Reset mid-WAIT after requester 0 last owned the bus.
        req_data = 32'h00002211;
        req      = 4'b0001;
        step();
        step();
        tx_int = 1'b1;
        step();
        check("rst_pre_ack", {28'd0, ack}, 32'h1);
        tx_int = 1'b0;
        req    = 4'b0010;
        step();
        step();
        check("rst_pre_grant", {28'd0, grant}, 32'h2);
        step();
        step();
        rst = 1'b1;
        req = 4'b0011;
        step();
        check("rst_outputs", {11'd0, err, grant, ack, busy, start_n, tx_data, tx_par},
              {11'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'h00, 2'b10});
        rst = 1'b0;
        step();
        check("rst_rearb", {28'd0, grant}, 32'h1);
        check("rst_rearb_ack", {28'd0, ack}, 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Interrupt never arrives: abort after 50 WAIT cycles.
        rst = 1'b1; req = 4'h0; tx_int = 1'b0;
        step();
        rst = 1'b0;
        req = 4'b0001;
        step();
        n = 0;
        do begin
            step();
            n++;
        end while (ack == 4'h0 && n < 100);
        check("to_cycles", n, 32'd51);
        check("to_ack", {28'd0, ack}, 32'h1);
        check("to_err", {31'd0, err}, 32'd1);
        req = 4'h0;
        step();
        check("to_idle", {30'd0, busy, err}, 32'd0);

        // Done in the 50th WAIT cycle beats the timeout.
        req = 4'b0001;
        step();
        repeat (50) step();
        check("to_race_wait", {28'd0, ack}, 32'd0);
        tx_int = 1'b1;
        step();
        check("to_race", {27'd0, ack, err}, {27'd0, 4'h1, 1'b0});
        tx_int = 1'b0;
        req    = 4'h0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
